// File: rtl/store_size_pkg.sv
// -----------------------------------------------------------------------------
// store_size_pkg
// Shared definitions for the store-narrowing path.
//   - sz_e     : store width encodings (2'b11 is folded into SZ_WORD on decode)
//   - state_e  : store sequencer states
//   - MEM_LAT_MIN / MEM_LAT_MAX : legal range of the memory read latency
//   - CNT_W    : width of the read-latency wait counter
//   - decode_size()   : maps the raw 2-bit size field onto sz_e
//   - is_misaligned() : alignment rule applied when the misalign check
//                       (STORE_SIZE_MISALIGN_CHECK_EN) is built in
// -----------------------------------------------------------------------------
package store_size_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } sz_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 3;
  localparam int unsigned CNT_W       = 2;

  // The unused encoding 2'b11 behaves as a full-word store.
  function automatic sz_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_size = SZ_HALF;
      2'b10:   decode_size = SZ_BYTE;
      default: decode_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input sz_e sz, input logic [1:0] offset);
    case (sz)
      SZ_HALF: is_misaligned = offset[0];
      SZ_BYTE: is_misaligned = 1'b0;
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
// Purely combinational lane merge for sub-word stores (little-endian lanes).
// Ports:
//   old_word [31:0] in  : word read back from memory
//   wdata    [31:0] in  : register value; low byte/half supplies the new lane
//   size            in  : decoded store width (sz_e)
//   offset   [1:0]  in  : byte offset within the word (addr[1:0])
//   merged   [31:0] out : old_word with the selected lane replaced
// Half stores select their lane on offset[1] only, so offset[0] is ignored.
// -----------------------------------------------------------------------------
module store_lane_merge
  import store_size_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  sz_e         size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    // NOTE: assigning a full default before the case keeps every path driven,
    // so no latch is inferred for lanes a branch does not touch.
    merged = old_word;
    case (size)
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/store_size_unit.sv
// -----------------------------------------------------------------------------
// store_size_unit
// Multi-cycle store path: narrows a 32-bit register value to word, half or
// byte and writes it to word-addressed memory. Word stores write directly;
// half/byte stores read the old word, merge the new lane and write back.
//
// Parameter:
//   MEM_LATENCY : cycles from a registered mem_addr to valid mem_rdata (1..3)
// Build option:
//   STORE_SIZE_MISALIGN_CHECK_EN : when defined, misaligned half/word requests
//   are rejected (done + misaligned pulse, no memory access). When undefined,
//   misaligned is tied low and the low address bits a width does not use are
//   ignored.
// Ports:
//   clk, reset (synchronous, active-high)
//   start, size[1:0], addr[31:0], wdata[31:0] : request (sampled in IDLE only)
//   mem_rdata[31:0]                           : memory read data
//   mem_addr[31:0], mem_wdata[31:0], mem_wr   : memory write port (registered)
//   busy, done, misaligned                    : status (registered)
// -----------------------------------------------------------------------------
module store_size_unit
  import store_size_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  if (MEM_LATENCY < MEM_LAT_MIN || MEM_LATENCY > MEM_LAT_MAX) begin : g_bad_latency
    $error("store_size_unit: MEM_LATENCY out of range 1..3");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);

  state_e           state;
  sz_e              size_q;
  logic [1:0]       offset_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      merged;
  sz_e              size_dec;
  logic             reject;
  logic             accept;

  assign size_dec = decode_size(size);
  assign accept   = (state == ST_IDLE) && start;

`ifdef STORE_SIZE_MISALIGN_CHECK_EN
  assign reject = is_misaligned(size_dec, addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) misaligned <= 1'b0;
    else       misaligned <= accept && reject;
  end
`else
  assign reject     = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Merge works from the captured request so that addr/size/wdata may change
  // freely while the read is outstanding.
  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .size     (size_q),
    .offset   (offset_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the captured request and datapath registers are reset along with
      // the FSM so every output, including mem_addr/mem_wdata, reads 0.
      state     <= ST_IDLE;
      size_q    <= SZ_WORD;
      offset_q  <= 2'b00;
      wdata_q   <= 32'h0;
      cnt       <= '0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Strobes default low; the branch that owns them raises them for one cycle.
      mem_wr <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            size_q   <= size_dec;
            offset_q <= addr[1:0];
            wdata_q  <= wdata;
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
            if (reject) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (size_dec == SZ_WORD) begin
              state     <= ST_WRITE;
              mem_wdata <= wdata;
              mem_wr    <= 1'b1;
            end else begin
              state <= ST_RD_WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end
        ST_RD_WAIT: begin
          // Counter reaches 0 in the cycle mem_rdata becomes valid.
          if (cnt == '0) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            state     <= ST_WRITE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WRITE: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_size_unit.sv
module tb_store_size_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start1, start3;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata1, rdata3, mem_word1, mem_word3;
  logic [31:0] mem_addr1, mem_wdata1, mem_addr3, mem_wdata3;
  logic        mem_wr1, busy1, done1, mis1;
  logic        mem_wr3, busy3, done3, mis3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t q1[$];
  wr_t q3[$];

  store_size_unit #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .size(size), .addr(addr),
    .wdata(wdata), .mem_rdata(rdata1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_wr(mem_wr1), .busy(busy1), .done(done1),
    .misaligned(mis1)
  );

  store_size_unit #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .size(size), .addr(addr),
    .wdata(wdata), .mem_rdata(rdata3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .busy(busy3), .done(done3),
    .misaligned(mis3)
  );

  // Memory stub: read data is only valid MEM_LATENCY cycles after the address
  // is presented (first busy cycle); before that it returns a poison pattern.
  int age1 = 0;
  int age3 = 0;
  always_ff @(posedge clk) begin
    age1 <= busy1 ? age1 + 1 : 0;
    age3 <= busy3 ? age3 + 1 : 0;
  end
  assign rdata1 = (busy1 && age1 >= 1) ? mem_word1 : 32'hBAD0_BAD0;
  assign rdata3 = (busy3 && age3 >= 3) ? mem_word3 : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_wr1) begin
      check("wr1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("wr1_addr", mem_addr1, e.a);
        check("wr1_data", mem_wdata1, e.d);
      end
    end
    if (mem_wr3) begin
      check("wr3_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        check("wr3_addr", mem_addr3, e.a);
        check("wr3_data", mem_wdata3, e.d);
      end
    end
  end

  // One store on DUT sel (0: latency 1, 1: latency 3). exp_wr = 0 means no write.
  task automatic do_store(input bit sel, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int exp_wr, input int exp_done,
                          input bit exp_mis, input logic [31:0] exp_data, input bit hold);
    int wr_c = 0;
    int done_c = 0;
    logic mis_seen = 1'b0;
    @(negedge clk);
    size = sz; addr = a; wdata = d;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    if (exp_wr != 0) begin
      if (sel) q3.push_back('{a: {a[31:2], 2'b00}, d: exp_data});
      else     q1.push_back('{a: {a[31:2], 2'b00}, d: exp_data});
    end
    for (int c = 1; c <= 12 && done_c == 0; c++) begin
      @(negedge clk);
      if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
      if (c == 1) check("busy_after_accept", 32'(sel ? busy3 : busy1), 32'd1);
      if (sel ? mem_wr3 : mem_wr1) wr_c = c;
      if (sel ? done3 : done1) begin
        done_c = c;
        mis_seen = sel ? mis3 : mis1;
      end
    end
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    check("busy_after_done", 32'(sel ? busy3 : busy1), 32'd0);
    check("wr_cycle", 32'(wr_c), 32'(exp_wr));
    check("done_cycle", 32'(done_c), 32'(exp_done));
    check("misaligned", 32'(mis_seen), 32'(exp_mis));
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    size = 2'b00; addr = 32'h0; wdata = 32'h0;
    mem_word1 = 32'h1122_3344; mem_word3 = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("rst_mem_addr1", mem_addr1, 32'h0);
    check("rst_mem_wdata1", mem_wdata1, 32'h0);
    check("rst_ctl1", {28'h0, mem_wr1, busy1, done1, mis1}, 32'h0);
    check("rst_mem_addr3", mem_addr3, 32'h0);
    check("rst_mem_wdata3", mem_wdata3, 32'h0);
    check("rst_ctl3", {28'h0, mem_wr3, busy3, done3, mis3}, 32'h0);
    reset = 1'b0;

    // Word store.
    do_store(1'b0, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 1, 2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // Byte store, lane 3.
    do_store(1'b0, 2'b10, 32'h0000_0103, 32'h0000_00AB, 3, 4, 1'b0, 32'hAB22_3344, 1'b0);
    // Half store, upper half.
    do_store(1'b0, 2'b01, 32'h0000_0202, 32'h0000_CAFE, 3, 4, 1'b0, 32'hCAFE_3344, 1'b0);
`ifdef STORE_SIZE_MISALIGN_CHECK_EN
    do_store(1'b0, 2'b01, 32'h0000_0201, 32'h0000_CAFE, 0, 1, 1'b1, 32'h0, 1'b0);
    do_store(1'b0, 2'b11, 32'h0000_0102, 32'h1234_5678, 0, 1, 1'b1, 32'h0, 1'b0);
`else
    do_store(1'b0, 2'b01, 32'h0000_0201, 32'h0000_CAFE, 3, 4, 1'b0, 32'h1122_CAFE, 1'b0);
    do_store(1'b0, 2'b11, 32'h0000_0102, 32'h1234_5678, 1, 2, 1'b0, 32'h1234_5678, 1'b0);
`endif
    // Start held high through busy (including DONE) must not create a second store.
    do_store(1'b0, 2'b00, 32'h0000_0300, 32'hA5A5_A5A5, 1, 2, 1'b0, 32'hA5A5_A5A5, 1'b1);
    repeat (4) @(negedge clk);
    check("no_requeue_busy", 32'(busy1), 32'd0);

    // Reset in the second RD_WAIT cycle of a byte store aborts it.
    @(negedge clk);
    size = 2'b10; addr = 32'h0000_0104; wdata = 32'h0000_0077; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("abort_busy_c1", 32'(busy1), 32'd1);
    @(negedge clk);
    reset = 1'b1; start1 = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_mem_wr", 32'(mem_wr1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    reset = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_quiet", {30'h0, mem_wr1, busy1}, 32'h0);
    end

    // Latency-3 instance.
    do_store(1'b1, 2'b10, 32'h0000_0001, 32'h0000_0055, 5, 6, 1'b0, 32'hFFFF_55FF, 1'b0);
    mem_word3 = 32'h0123_4567;
    do_store(1'b1, 2'b01, 32'h0000_0002, 32'h0000_BEEF, 5, 6, 1'b0, 32'hBEEF_4567, 1'b0);

    repeat (2) @(negedge clk);
    check("sb1_drained", 32'(q1.size()), 32'd0);
    check("sb3_drained", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
